// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - multi-wide in-order commit stage with store back-pressure and redirect flush window
module commit_unit #(
    parameter int COMMIT_WIDTH   = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int INSTR_ID_WIDTH = 6,
    parameter int FLUSH_CYCLES   = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   rdy_in,
    input  logic [COMMIT_WIDTH-1:0]                head_valid_in,
    input  logic [COMMIT_WIDTH*INSTR_ID_WIDTH-1:0] head_id_in,
    input  logic [COMMIT_WIDTH-1:0]                head_jump_en_in,
    input  logic [COMMIT_WIDTH*ADDR_WIDTH-1:0]     head_jump_a_in,
    input  logic                                   lsb_w_ready_in,
    output logic [$clog2(COMMIT_WIDTH+1)-1:0]      commit_pop_out,
    output logic [COMMIT_WIDTH-1:0]                commit_to_regfile_en_out,
    output logic                                   commit_to_lsb_w_en_out,
    output logic                                   commit_to_pc_en_out,
    output logic [ADDR_WIDTH-1:0]                  commit_to_pc_out,
    output logic                                   clear_branch_out,
    output logic [CNT_WIDTH-1:0]                   retired_cnt_out
);

    localparam int PW  = $clog2(COMMIT_WIDTH + 1);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam int IW  = INSTR_ID_WIDTH;

    // Instruction id encoding: loads, stores, LUI/AUIPC, JAL/JALR, branches, then ALU ops.
    localparam logic [IW-1:0] ID_LHU  = IW'(4);
    localparam logic [IW-1:0] ID_SB   = IW'(5);
    localparam logic [IW-1:0] ID_SW   = IW'(7);
    localparam logic [IW-1:0] ID_LUI  = IW'(8);
    localparam logic [IW-1:0] ID_JAL  = IW'(10);
    localparam logic [IW-1:0] ID_JALR = IW'(11);
    localparam logic [IW-1:0] ID_BGEU = IW'(17);
    localparam logic [IW-1:0] ID_ADDI = IW'(18);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [FCW-1:0]          r_flush_cnt;
    logic [FCW-1:0]          w_flush_cnt_next;

    logic [COMMIT_WIDTH-1:0] w_retire;
    logic [COMMIT_WIDTH-1:0] w_wreg;
    logic [PW-1:0]           w_pop;
    logic                    w_store_ret;
    logic                    w_jump_ret;
    logic [ADDR_WIDTH-1:0]   w_jump_target;
    logic                    w_stop;
    logic                    w_can_commit;

    logic [COMMIT_WIDTH-1:0] r_regfile_en;
    logic                    r_lsb_w_en;
    logic                    r_pc_en;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic                    r_clear_branch;
    logic [CNT_WIDTH-1:0]    r_retired_cnt;

    function automatic logic is_wreg(input logic [IW-1:0] id);
        return (id <= ID_LHU) || ((id >= ID_LUI) && (id <= ID_JALR)) || (id >= ID_ADDI);
    endfunction

    function automatic logic is_ctrl(input logic [IW-1:0] id);
        return (id >= ID_JAL) && (id <= ID_BGEU);
    endfunction

    function automatic logic is_store(input logic [IW-1:0] id);
        return (id >= ID_SB) && (id <= ID_SW);
    endfunction

    assign w_can_commit = (r_state == ST_RUN) && rdy_in && !rst_in;

    // In-order scan of the head window; the first blocking slot ends retirement for this cycle.
    always_comb begin
        w_retire      = '0;
        w_wreg        = '0;
        w_pop         = '0;
        w_store_ret   = 1'b0;
        w_jump_ret    = 1'b0;
        w_jump_target = '0;
        w_stop        = !w_can_commit;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_wreg[i] = is_wreg(head_id_in[i*IW +: IW]);
            if (!w_stop) begin
                if (!head_valid_in[i]) begin
                    w_stop = 1'b1;
                end else if (is_store(head_id_in[i*IW +: IW])) begin
                    // Only one store per cycle, and only when the LSB can take it.
                    if (lsb_w_ready_in && !w_store_ret) begin
                        w_retire[i] = 1'b1;
                        w_store_ret = 1'b1;
                        w_pop       = w_pop + PW'(1);
                    end else begin
                        w_stop = 1'b1;
                    end
                end else begin
                    w_retire[i] = 1'b1;
                    w_pop       = w_pop + PW'(1);
                    if (is_ctrl(head_id_in[i*IW +: IW]) && head_jump_en_in[i]) begin
                        w_jump_ret    = 1'b1;
                        w_jump_target = head_jump_a_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                        w_stop        = 1'b1;
                    end
                end
            end
        end
    end

    assign commit_pop_out = w_pop;

    // Next state: enter the flush window on a taken redirect, leave it when the count runs out.
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        if (rdy_in) begin
            case (r_state)
                ST_RUN: begin
                    if (w_jump_ret) begin
                        w_state_next     = ST_FLUSH;
                        w_flush_cnt_next = FCW'(FLUSH_CYCLES);
                    end
                end
                ST_FLUSH: begin
                    w_flush_cnt_next = r_flush_cnt - FCW'(1);
                    if (r_flush_cnt == FCW'(1)) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next     = ST_RUN;
                    w_flush_cnt_next = '0;
                end
            endcase
        end
    end

    // State and flush counter registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    // Registered retirement side-effects; each pulse lasts one cycle, pc target holds while frozen.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_regfile_en   <= '0;
            r_lsb_w_en     <= 1'b0;
            r_pc_en        <= 1'b0;
            r_pc           <= '0;
            r_clear_branch <= 1'b0;
            r_retired_cnt  <= '0;
        end else if (rdy_in) begin
            r_regfile_en   <= w_retire & w_wreg;
            r_lsb_w_en     <= w_store_ret;
            r_pc_en        <= w_jump_ret;
            r_pc           <= w_jump_ret ? w_jump_target : '0;
            r_clear_branch <= w_jump_ret;
            r_retired_cnt  <= r_retired_cnt + CNT_WIDTH'(w_pop);
        end else begin
            r_regfile_en   <= '0;
            r_lsb_w_en     <= 1'b0;
            r_pc_en        <= 1'b0;
            r_clear_branch <= 1'b0;
        end
    end

    assign commit_to_regfile_en_out = r_regfile_en;
    assign commit_to_lsb_w_en_out   = r_lsb_w_en;
    assign commit_to_pc_en_out      = r_pc_en;
    assign commit_to_pc_out         = r_pc;
    assign clear_branch_out         = r_clear_branch;
    assign retired_cnt_out          = r_retired_cnt;

endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - directed self-checking bench for commit_unit
module tb_commit_unit;

    localparam int W  = 2;
    localparam int AW = 32;
    localparam int IW = 6;
    localparam int CW = 32;

    localparam logic [IW-1:0] SB   = 6'd5;
    localparam logic [IW-1:0] SH   = 6'd6;
    localparam logic [IW-1:0] SW   = 6'd7;
    localparam logic [IW-1:0] JAL  = 6'd10;
    localparam logic [IW-1:0] BEQ  = 6'd12;
    localparam logic [IW-1:0] BNE  = 6'd13;
    localparam logic [IW-1:0] ADDI = 6'd18;
    localparam logic [IW-1:0] ADD  = 6'd27;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [W-1:0]      valid;
    logic [IW-1:0]     id0, id1;
    logic [W-1:0]      jen;
    logic [AW-1:0]     ja0, ja1;
    logic              lsb_rdy;
    logic [1:0]        pop;
    logic [W-1:0]      rf_en;
    logic              lsb_en;
    logic              pc_en;
    logic [AW-1:0]     pc;
    logic              clr;
    logic [CW-1:0]     cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    commit_unit #(
        .COMMIT_WIDTH(W), .ADDR_WIDTH(AW), .INSTR_ID_WIDTH(IW),
        .FLUSH_CYCLES(2), .CNT_WIDTH(CW)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .rdy_in(rdy),
        .head_valid_in(valid),
        .head_id_in({id1, id0}),
        .head_jump_en_in(jen),
        .head_jump_a_in({ja1, ja0}),
        .lsb_w_ready_in(lsb_rdy),
        .commit_pop_out(pop),
        .commit_to_regfile_en_out(rf_en),
        .commit_to_lsb_w_en_out(lsb_en),
        .commit_to_pc_en_out(pc_en),
        .commit_to_pc_out(pc),
        .clear_branch_out(clr),
        .retired_cnt_out(cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic heads(input logic [W-1:0] v, input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                         input logic [W-1:0] j, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        valid = v; id0 = i0; id1 = i1; jen = j; ja0 = a0; ja1 = a1;
        #1;
    endtask

    task automatic regs(input string tag, input logic [W-1:0] e_rf, input logic e_lsb,
                        input logic e_pcen, input logic [AW-1:0] e_pc, input logic e_clr,
                        input logic [CW-1:0] e_cnt);
        check({tag, ".rf_en"}, 64'(rf_en), 64'(e_rf));
        check({tag, ".lsb_en"}, 64'(lsb_en), 64'(e_lsb));
        check({tag, ".pc_en"}, 64'(pc_en), 64'(e_pcen));
        check({tag, ".pc"}, 64'(pc), 64'(e_pc));
        check({tag, ".clr"}, 64'(clr), 64'(e_clr));
        check({tag, ".cnt"}, 64'(cnt), 64'(e_cnt));
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; lsb_rdy = 1'b1;
        heads(2'b11, ADDI, ADDI, 2'b00, 0, 0);
        check("rst_pop", 64'(pop), 0);
        tick(); tick();
        regs("reset", 2'b00, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // two ALU ops retire together
        heads(2'b11, ADDI, ADDI, 2'b00, 0, 0);
        check("alu_pop", 64'(pop), 2);
        tick();
        regs("alu", 2'b11, 0, 0, 0, 0, 2);

        // store blocked by LSB back-pressure, then released
        lsb_rdy = 1'b0;
        heads(2'b11, SW, ADD, 2'b00, 0, 0);
        check("sw_blk_pop", 64'(pop), 0);
        tick();
        regs("sw_blk", 2'b00, 0, 0, 0, 0, 2);
        lsb_rdy = 1'b1;
        #1;
        check("sw_go_pop", 64'(pop), 2);
        tick();
        regs("sw_go", 2'b10, 1, 0, 0, 0, 4);

        // two stores: only the first retires
        heads(2'b11, SB, SH, 2'b00, 0, 0);
        check("sb_sh_pop", 64'(pop), 1);
        tick();
        regs("sb_sh", 2'b00, 1, 0, 0, 0, 5);
        heads(2'b01, SH, ADDI, 2'b00, 0, 0);
        check("sh_pop", 64'(pop), 1);
        tick();
        regs("sh", 2'b00, 1, 0, 0, 0, 6);

        // ALU then store with LSB not ready
        lsb_rdy = 1'b0;
        heads(2'b11, ADDI, SW, 2'b00, 0, 0);
        check("alu_sw_pop", 64'(pop), 1);
        tick();
        regs("alu_sw", 2'b01, 0, 0, 0, 0, 7);
        lsb_rdy = 1'b1;

        // taken branch, then two-cycle flush window
        heads(2'b11, BEQ, ADDI, 2'b01, 32'h1000, 0);
        check("beq_pop", 64'(pop), 1);
        tick();
        regs("beq", 2'b00, 0, 1, 32'h1000, 1, 8);
        heads(2'b11, ADDI, ADDI, 2'b00, 0, 0);
        check("flush1_pop", 64'(pop), 0);
        tick();
        regs("flush1", 2'b00, 0, 0, 0, 0, 8);
        check("flush2_pop", 64'(pop), 0);
        tick();
        check("resume_pop", 64'(pop), 2);
        tick();
        regs("resume", 2'b11, 0, 0, 0, 0, 10);

        // taken redirect in slot 1
        heads(2'b11, ADDI, BNE, 2'b10, 0, 32'h2468);
        check("s1br_pop", 64'(pop), 2);
        tick();
        regs("s1br", 2'b01, 0, 1, 32'h2468, 1, 12);
        tick(); tick();

        // JAL taken, reset during flush
        heads(2'b11, JAL, ADDI, 2'b01, 32'h2000, 0);
        check("jal_pop", 64'(pop), 1);
        tick();
        regs("jal", 2'b01, 0, 1, 32'h2000, 1, 13);
        rst = 1'b1;
        tick();
        regs("rst_flush", 2'b00, 0, 0, 0, 0, 0);
        check("rst_flush_pop", 64'(pop), 0);
        rst = 1'b0;
        heads(2'b01, ADDI, ADDI, 2'b00, 0, 0);
        check("post_rst_pop", 64'(pop), 1);
        tick();
        regs("post_rst", 2'b01, 0, 0, 0, 0, 1);

        // redirect then freeze during flush: pc target holds, flush count holds
        heads(2'b11, BNE, ADDI, 2'b01, 32'h3000, 0);
        tick();
        regs("bne", 2'b00, 0, 1, 32'h3000, 1, 2);
        rdy = 1'b0;
        heads(2'b11, ADDI, ADDI, 2'b00, 0, 0);
        check("frz_pop", 64'(pop), 0);
        tick(); tick();
        regs("frz_flush", 2'b00, 0, 0, 32'h3000, 0, 2);
        rdy = 1'b1;
        #1;
        check("unfrz1_pop", 64'(pop), 0);
        tick();
        check("unfrz2_pop", 64'(pop), 0);
        tick();
        check("unfrz3_pop", 64'(pop), 2);

        // freeze in RUN with valid heads
        rdy = 1'b0;
        #1;
        check("frz_run_pop", 64'(pop), 0);
        tick();
        regs("frz_run", 2'b00, 0, 0, 0, 0, 2);
        rdy = 1'b1;
        #1;
        check("thaw_pop", 64'(pop), 2);
        tick();
        regs("thaw", 2'b11, 0, 0, 0, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
